fifo_tmr_param: RTL and testbench
=================================

# fifo_tmr_param

Parametrised, radiation-tolerant synchronous FIFO. It is the next-generation byte/word buffer between the UART core's shift logic and the host bus. It generalises data width and depth, and the triple-modular-redundant (TMR) pointers are optional. It adds a selectable overwrite-on-full mode, programmable near-full and near-empty thresholds, sticky overflow and underflow flags, and an SEU-detected pulse.

## Interface
- DATA_W, 8, data word width (1..32)
- DEPTH, 16, number of storage entries (2..65535); any integer, not necessarily a power of two
- TMR_EN, 1, 1 = pointers, count and flags triplicated with majority vote; 0 = single copy
- OVERWRITE, 0, 0 = write on full is dropped; 1 = write on full discards the oldest entry
- NEARFULL_LVL, (DEPTH*3)/4, p_nearfull_o asserted when count >= this value
- NEAREMPTY_LVL, DEPTH/4, p_nearempty_o asserted when count <= this value
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-low
- data_i  input  DATA_W  write data
- n_we_i  input  1  write request, active-low
- n_re_i  input  1  read request, active-low
- n_clr_i  input  1  synchronous clear, active-low
- data_o  output  DATA_W  registered read data
- p_rvalid_o  output  1  one-cycle pulse: data_o updated
- bytes_in_fifo_o  output  CNT_W  entry count, CNT_W = clog2(DEPTH+1)
- p_empty_o, p_full_o, p_nearfull_o, p_nearempty_o  output  1 each  status flags
- p_over_o  output  1  sticky overflow
- p_under_o  output  1  sticky underflow
- p_seu_o  output  1  one-cycle pulse on any TMR copy disagreement

## Operation
- Reset (rst low at edge) and clear (n_clr_i low at edge) are identical in effect:
  - pointers = 0, count = 0, data_o = 0, p_rvalid_o = 0
  - p_empty_o = 1 and p_nearempty_o = 1; all other flags = 0
  - clear overrides any read or write in the same cycle
  - memory contents are not cleared
- Read is accepted when n_re_i = 0 and the FIFO is not empty. data_o takes mem[rd_ptr], rd_ptr advances, p_rvalid_o pulses.
- Read when empty: ignored. data_o holds, p_under_o is set.
- Write when not full: mem[wr_ptr] = data_i, wr_ptr advances.
- Simultaneous read and write, not empty: both are accepted and the count is unchanged.
- Simultaneous read and write, empty: the write is accepted and the read is rejected (p_under_o set). There is no fall-through.
- Simultaneous read and write, full: both are accepted. The count stays DEPTH and p_over_o is not set.
- Write when full with no read:
  - OVERWRITE = 0: data is dropped and p_over_o is set.
  - OVERWRITE = 1: data is written at wr_ptr, rd_ptr advances (the oldest entry is lost), the count stays DEPTH, and p_over_o is set.
- p_over_o and p_under_o are sticky. Only rst or n_clr_i clears them.
- Pointer wrap: a pointer equal to DEPTH-1 advances to 0. There is no reliance on a power-of-two DEPTH.
- Count is an explicit register (+1 on write only, -1 on read only), so all DEPTH entries are usable.
- Flags are registered and computed from the next count, so they are coherent with bytes_in_fifo_o on every cycle.
- TMR (TMR_EN = 1):
  - Applies to wr_ptr, rd_ptr, count, the sticky flags and the status flags.
  - Each is held in three copies. The value used is the bitwise majority (2-of-3 per bit).
  - All three copies are rewritten with the voted next value every cycle (scrubbing).
  - p_seu_o pulses in the cycle after any copy disagreed with the vote.
  - The memory array is not triplicated.

## Timing
- Write accepted at edge k: bytes_in_fifo_o and flags reflect it after edge k. The data is readable by a read sampled at edge k+1.
- Read accepted at edge k: data_o and p_rvalid_o are valid after edge k (latency 1). p_rvalid_o falls after k+1 unless another read is accepted.
- Back-to-back reads: one word per cycle, no bubbles.
- A single corrupted copy is corrected within one cycle with no functional effect.

## Structure
- Shared package fifo_pkg holds:
  - function maj3 (bitwise vote)
  - function clog2
  - defaults for DATA_W, DEPTH, NEARFULL_LVL and NEAREMPTY_LVL
- Sub-module tmr_reg (parameter W, TMR_EN): holds three copies of a register, performs the synchronous active-low reset to a parameterised init value, and provides the voted output and a mismatch flag.
- The top instantiates tmr_reg for each pointer, the count and the flag vectors. It ORs the mismatch flags into p_seu_o.

## Test plan
All scenarios use DATA_W=8, DEPTH=5, TMR_EN=1 and the default levels (NEARFULL_LVL=3, NEAREMPTY_LVL=1).

- Fill and drain:
  - Write 0x11..0x55: bytes_in_fifo_o reaches 5 with p_full_o=1; p_nearfull_o=1 from count 3.
  - Read 5 times: data_o = 0x11..0x55, each with p_rvalid_o and latency 1; p_empty_o=1 at the end.
- Overflow, OVERWRITE=0: after the fill, write 0x66 -> p_over_o=1, count 5; reads return 0x11..0x55.
- Overflow, OVERWRITE=1: after the fill, write 0x66 -> p_over_o=1; reads return 0x22,0x33,0x44,0x55,0x66.
- Underflow and simultaneous access:
  - Read while empty -> p_under_o=1 and data_o unchanged.
  - Read and write together while empty -> count 1, p_rvalid_o=0.
  - Read and write together while full -> count stays 5.
- Wrap and clear:
  - Run 12 interleaved write/read pairs so the pointers cross 4->0 twice; data order is preserved.
  - Assert n_clr_i together with n_we_i -> count 0, p_empty_o=1, sticky flags 0, and the write is ignored.
- SEU: force one copy of rd_ptr to 3 while the true value is 1 -> p_seu_o pulses once, the next read returns the correct word, and all copies equal 2 afterwards. A reset mid-fill returns every output to its reset value.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types, defaults and voting helpers for the TMR FIFO
package fifo_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_NEARFULL_LVL = (DEF_DEPTH * 3) / 4;
    localparam int DEF_NEAREMPTY_LVL = DEF_DEPTH / 4;
    typedef struct packed {
        logic empty;
        logic full;
        logic nearfull;
        logic nearempty;
    } status_t;
    typedef struct packed {
        logic over;
        logic under;
    } sticky_t;
    localparam status_t STATUS_INIT = '{empty: 1'b1, full: 1'b0, nearfull: 1'b0, nearempty: 1'b1};
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic logic [31:0] maj3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/tmr_reg.sv
// tmr_reg: triplicated register with bitwise vote, scrubbing and mismatch flag
module tmr_reg
    import fifo_pkg::*;
#(
    parameter int W = 1,
    parameter bit TMR_EN = 1'b1,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         mismatch
);
    logic [W-1:0] r0, r1, r2;
    // every copy takes the voted next value, so a single upset lives one cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r0 <= INIT;
            r1 <= INIT;
            r2 <= INIT;
        end else begin
            r0 <= d;
            r1 <= d;
            r2 <= d;
        end
    end
    assign q = TMR_EN ? W'(maj3(32'(r0), 32'(r1), 32'(r2))) : r0;
    assign mismatch = TMR_EN && (r0 != r1 || r1 != r2);
endmodule

// File: rtl/fifo_tmr_param.sv
// fifo_tmr_param: parametrised synchronous FIFO with optional TMR control state
module fifo_tmr_param
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter bit TMR_EN = 1'b1,
    parameter bit OVERWRITE = 1'b0,
    parameter int NEARFULL_LVL = (DEPTH * 3) / 4,
    parameter int NEAREMPTY_LVL = DEPTH / 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            data_i,
    input  logic                         n_we_i,
    input  logic                         n_re_i,
    input  logic                         n_clr_i,
    output logic [DATA_W-1:0]            data_o,
    output logic                         p_rvalid_o,
    output logic [clog2(DEPTH+1)-1:0]    bytes_in_fifo_o,
    output logic                         p_empty_o,
    output logic                         p_full_o,
    output logic                         p_nearfull_o,
    output logic                         p_nearempty_o,
    output logic                         p_over_o,
    output logic                         p_under_o,
    output logic                         p_seu_o
);
    localparam int CNT_W = clog2(DEPTH + 1);
    localparam int PTR_W = clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] NF_C = CNT_W'(NEARFULL_LVL);
    localparam logic [CNT_W-1:0] NE_C = CNT_W'(NEAREMPTY_LVL);
    localparam logic [PTR_W-1:0] LAST_P = PTR_W'(DEPTH - 1);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    status_t st, st_nxt;
    sticky_t sk, sk_nxt;
    logic [4:0] mis;
    logic clr, full_now, rd_ok, wr_ok, drop;
    always_comb begin
        clr = !n_clr_i;
        full_now = cnt == FULL_C;
        rd_ok = !n_re_i && cnt != '0;
        // a write that meets a full FIFO with no read to make room
        drop = !n_we_i && full_now && !rd_ok;
        wr_ok = !n_we_i && (!drop || OVERWRITE);
        wr_nxt = clr ? '0 : wr_ok ? (wr_ptr == LAST_P ? '0 : wr_ptr + 1'b1) : wr_ptr;
        rd_nxt = clr ? '0 : (rd_ok || (drop && OVERWRITE)) ? (rd_ptr == LAST_P ? '0 : rd_ptr + 1'b1) : rd_ptr;
        cnt_nxt = clr ? '0 : (wr_ok && !rd_ok && !full_now) ? cnt + 1'b1 : (rd_ok && !wr_ok) ? cnt - 1'b1 : cnt;
        st_nxt = clr ? STATUS_INIT : status_t'{empty: cnt_nxt == '0, full: cnt_nxt == FULL_C,
                                               nearfull: cnt_nxt >= NF_C, nearempty: cnt_nxt <= NE_C};
        sk_nxt = clr ? '0 : sticky_t'{over: sk.over | drop, under: sk.under | (!n_re_i && cnt == '0)};
    end
    tmr_reg #(.W(PTR_W), .TMR_EN(TMR_EN)) u_wr (
        .clk(clk), .rst(rst), .d(wr_nxt), .q(wr_ptr), .mismatch(mis[0])
    );
    tmr_reg #(.W(PTR_W), .TMR_EN(TMR_EN)) u_rd (
        .clk(clk), .rst(rst), .d(rd_nxt), .q(rd_ptr), .mismatch(mis[1])
    );
    tmr_reg #(.W(CNT_W), .TMR_EN(TMR_EN)) u_cnt (
        .clk(clk), .rst(rst), .d(cnt_nxt), .q(cnt), .mismatch(mis[2])
    );
    tmr_reg #(.W($bits(status_t)), .TMR_EN(TMR_EN), .INIT(STATUS_INIT)) u_st (
        .clk(clk), .rst(rst), .d(st_nxt), .q(st), .mismatch(mis[3])
    );
    tmr_reg #(.W($bits(sticky_t)), .TMR_EN(TMR_EN)) u_sk (
        .clk(clk), .rst(rst), .d(sk_nxt), .q(sk), .mismatch(mis[4])
    );
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            data_o <= '0;
            p_rvalid_o <= 1'b0;
        end else begin
            p_rvalid_o <= rd_ok;
            if (rd_ok) data_o <= mem[rd_ptr];
        end
    end
    always_ff @(posedge clk) begin
        if (rst && !clr && wr_ok) mem[wr_ptr] <= data_i;
    end
    always_ff @(posedge clk) begin
        p_seu_o <= rst ? |mis : 1'b0;
    end
    assign bytes_in_fifo_o = cnt;
    assign p_empty_o = st.empty;
    assign p_full_o = st.full;
    assign p_nearfull_o = st.nearfull;
    assign p_nearempty_o = st.nearempty;
    assign p_over_o = sk.over;
    assign p_under_o = sk.under;
endmodule

// File: tb/tb_fifo_tmr_param.sv
// tb_fifo_tmr_param: drop and overwrite variants against a queue-based reference
module tb_fifo_tmr_param;
    logic clk = 1'b0, rst = 1'b0, n_we_i = 1'b1, n_re_i = 1'b1, n_clr_i = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic [7:0] dout [2];
    logic [2:0] cnt [2];
    logic rv [2], emp [2], ful [2], nf [2], ne [2], ov [2], un [2], seu [2];
    int errs = 0, checks = 0;
    logic [7:0] mq0 [$], mq1 [$];
    logic [7:0] md [2];
    bit mrv [2], mov [2], mun [2];
    always #5 clk = ~clk;
    fifo_tmr_param #(.DATA_W(8), .DEPTH(5), .TMR_EN(1'b1), .OVERWRITE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .data_i(data_i), .n_we_i(n_we_i), .n_re_i(n_re_i), .n_clr_i(n_clr_i),
        .data_o(dout[0]), .p_rvalid_o(rv[0]), .bytes_in_fifo_o(cnt[0]), .p_empty_o(emp[0]),
        .p_full_o(ful[0]), .p_nearfull_o(nf[0]), .p_nearempty_o(ne[0]), .p_over_o(ov[0]),
        .p_under_o(un[0]), .p_seu_o(seu[0])
    );
    fifo_tmr_param #(.DATA_W(8), .DEPTH(5), .TMR_EN(1'b1), .OVERWRITE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .data_i(data_i), .n_we_i(n_we_i), .n_re_i(n_re_i), .n_clr_i(n_clr_i),
        .data_o(dout[1]), .p_rvalid_o(rv[1]), .bytes_in_fifo_o(cnt[1]), .p_empty_o(emp[1]),
        .p_full_o(ful[1]), .p_nearfull_o(nf[1]), .p_nearempty_o(ne[1]), .p_over_o(ov[1]),
        .p_under_o(un[1]), .p_seu_o(seu[1])
    );
    task automatic model(input bit ow, inout logic [7:0] q [$], inout logic [7:0] d, inout bit rv_m,
                         inout bit ov_m, inout bit un_m, input bit we, input bit re, input bit cl,
                         input logic [7:0] din);
        bit rd, full;
        if (cl) begin
            q.delete();
            d = 8'h00;
            rv_m = 0;
            ov_m = 0;
            un_m = 0;
        end else begin
            rd = re && q.size() > 0;
            full = q.size() == 5;
            rv_m = rd;
            if (rd) d = q.pop_front();
            if (re && !rd) un_m = 1;
            if (we) begin
                if (!full || rd) q.push_back(din);
                else begin
                    ov_m = 1;
                    if (ow) begin
                        void'(q.pop_front());
                        q.push_back(din);
                    end
                end
            end
        end
    endtask
    task automatic drive(input bit we, input bit re, input bit cl, input bit rs, input logic [7:0] din);
        n_we_i = !we;
        n_re_i = !re;
        n_clr_i = !cl;
        rst = !rs;
        data_i = din;
        model(1'b0, mq0, md[0], mrv[0], mov[0], mun[0], we, re, cl || rs, din);
        model(1'b1, mq1, md[1], mrv[1], mov[1], mun[1], we, re, cl || rs, din);
        @(posedge clk);
        #1;
        n_we_i = 1'b1;
        n_re_i = 1'b1;
        n_clr_i = 1'b1;
        rst = 1'b1;
    endtask
    function automatic int msz(input int i);
        return i != 0 ? mq1.size() : mq0.size();
    endfunction
    task automatic test_reset();
        drive(1, 1, 0, 1, 8'hA5);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({cnt[i], emp[i], ful[i], nf[i], ne[i], ov[i], un[i], rv[i], seu[i], dout[i]} !== {3'd0, 8'b10010000, 8'h00}) begin
                errs++;
                $display("FAIL reset dut%0d got cnt=%0d e/f/nf/ne/ov/un/rv/seu=%b%b%b%b%b%b%b%b d=%h want cnt=0 10010000 d=00",
                         i, cnt[i], emp[i], ful[i], nf[i], ne[i], ov[i], un[i], rv[i], seu[i], dout[i]);
            end
        end
    endtask
    task automatic test_fill_drain();
        for (int k = 1; k <= 5; k++) begin
            drive(1, 0, 0, 0, 8'(k * 'h11));
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({cnt[i], emp[i], ful[i], nf[i], ne[i]} !== {3'(msz(i)), msz(i) == 0, msz(i) == 5, msz(i) >= 3, msz(i) <= 1}) begin
                    errs++;
                    $display("FAIL fill_status dut%0d got cnt=%0d e/f/nf/ne=%b%b%b%b want cnt=%0d", i, cnt[i], emp[i], ful[i], nf[i], ne[i], msz(i));
                end
            end
        end
        checks++;
        if ({cnt[0], ful[0]} !== {3'd5, 1'b1}) begin
            errs++;
            $display("FAIL fill_full got cnt=%0d full=%b want 5 1", cnt[0], ful[0]);
        end
        for (int k = 1; k <= 5; k++) begin
            drive(0, 1, 0, 0, 8'h00);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dout[i] !== 8'(k * 'h11) || rv[i] !== 1'b1 || dout[i] !== md[i]) begin
                    errs++;
                    $display("FAIL drain_data dut%0d got %h rv=%b want %h rv=1", i, dout[i], rv[i], 8'(k * 'h11));
                end
            end
        end
        drive(0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rv[i] !== 1'b0 || emp[i] !== 1'b1 || dout[i] !== 8'h55) begin
                errs++;
                $display("FAIL drain_end dut%0d got rv=%b empty=%b d=%h want 0 1 55", i, rv[i], emp[i], dout[i]);
            end
        end
    endtask
    task automatic test_overflow();
        for (int k = 1; k <= 6; k++) drive(1, 0, 0, 0, 8'(k * 'h11));
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ov[i] !== 1'b1 || cnt[i] !== 3'd5 || ov[i] !== mov[i]) begin
                errs++;
                $display("FAIL overflow_flag dut%0d got over=%b cnt=%0d want 1 5", i, ov[i], cnt[i]);
            end
        end
        for (int k = 1; k <= 5; k++) begin
            drive(0, 1, 0, 0, 8'h00);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dout[i] !== 8'((k + i) * 'h11) || dout[i] !== md[i]) begin
                    errs++;
                    $display("FAIL overflow_data dut%0d got %h want %h", i, dout[i], 8'((k + i) * 'h11));
                end
            end
        end
    endtask
    task automatic test_underflow();
        drive(0, 0, 1, 0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ov[i] !== 1'b0 || un[i] !== 1'b0 || dout[i] !== 8'h00) begin
                errs++;
                $display("FAIL clear_sticky dut%0d got over=%b under=%b d=%h want 0 0 00", i, ov[i], un[i], dout[i]);
            end
        end
        drive(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (un[i] !== 1'b1 || rv[i] !== 1'b0 || dout[i] !== md[i]) begin
                errs++;
                $display("FAIL underflow dut%0d got under=%b rv=%b d=%h want 1 0 %h", i, un[i], rv[i], dout[i], md[i]);
            end
        end
        drive(1, 1, 0, 0, 8'($urandom));
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (cnt[i] !== 3'd1 || rv[i] !== 1'b0) begin
                errs++;
                $display("FAIL rw_empty dut%0d got cnt=%0d rv=%b want 1 0", i, cnt[i], rv[i]);
            end
        end
        for (int k = 0; k < 4; k++) drive(1, 0, 0, 0, 8'($urandom));
        drive(1, 1, 0, 0, 8'($urandom));
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (cnt[i] !== 3'd5 || ov[i] !== 1'b0 || rv[i] !== 1'b1 || dout[i] !== md[i]) begin
                errs++;
                $display("FAIL rw_full dut%0d got cnt=%0d over=%b rv=%b d=%h want 5 0 1 %h", i, cnt[i], ov[i], rv[i], dout[i], md[i]);
            end
        end
    endtask
    task automatic test_wrap();
        logic [7:0] w;
        drive(0, 0, 1, 0, 8'h00);
        for (int k = 0; k < 12; k++) begin
            w = 8'($urandom);
            drive(1, 0, 0, 0, w);
            drive(0, 1, 0, 0, 8'h00);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dout[i] !== w || rv[i] !== 1'b1 || cnt[i] !== 3'd0) begin
                    errs++;
                    $display("FAIL wrap pair%0d dut%0d got %h rv=%b cnt=%0d want %h 1 0", k, i, dout[i], rv[i], cnt[i], w);
                end
            end
        end
    endtask
    task automatic test_clear();
        drive(0, 1, 0, 0, 8'h00);
        for (int k = 0; k < 6; k++) drive(1, 0, 0, 0, 8'($urandom));
        drive(1, 0, 1, 0, 8'hEE);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({cnt[i], emp[i], ful[i], nf[i], ne[i], ov[i], un[i], rv[i]} !== {3'd0, 7'b1001000}) begin
                errs++;
                $display("FAIL clear dut%0d got cnt=%0d e/f/nf/ne/ov/un/rv=%b%b%b%b%b%b%b want cnt=0 1001000",
                         i, cnt[i], emp[i], ful[i], nf[i], ne[i], ov[i], un[i], rv[i]);
            end
        end
        drive(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rv[i] !== 1'b0 || un[i] !== 1'b1) begin
                errs++;
                $display("FAIL clear_write_ignored dut%0d got rv=%b under=%b want 0 1", i, rv[i], un[i]);
            end
        end
    endtask
    task automatic test_seu();
        drive(0, 0, 1, 0, 8'h00);
        for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, 8'($urandom));
        drive(0, 1, 0, 0, 8'h00);
        @(negedge clk);
        force dut0.u_rd.r1 = 3'd3;
        #1;
        release dut0.u_rd.r1;
        drive(0, 1, 0, 0, 8'h00);
        checks++;
        if (dout[0] !== md[0] || rv[0] !== 1'b1) begin
            errs++;
            $display("FAIL seu_read got %h rv=%b want %h 1", dout[0], rv[0], md[0]);
        end
        checks++;
        if (seu[0] !== 1'b1 || seu[1] !== 1'b0) begin
            errs++;
            $display("FAIL seu_pulse got dut0=%b dut1=%b want 1 0", seu[0], seu[1]);
        end
        checks++;
        if ({dut0.u_rd.r0, dut0.u_rd.r1, dut0.u_rd.r2} !== {3'd2, 3'd2, 3'd2}) begin
            errs++;
            $display("FAIL seu_scrub got %0d %0d %0d want 2 2 2", dut0.u_rd.r0, dut0.u_rd.r1, dut0.u_rd.r2);
        end
        drive(0, 0, 0, 0, 8'h00);
        checks++;
        if (seu[0] !== 1'b0) begin
            errs++;
            $display("FAIL seu_once got %b want 0", seu[0]);
        end
    endtask
    task automatic test_random();
        bit we, re, cl;
        drive(0, 0, 1, 0, 8'h00);
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 2) == 0);
            cl = $urandom_range(0, 40) == 0;
            drive(we, re, cl, 0, 8'($urandom));
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({dout[i], cnt[i], emp[i], ful[i], nf[i], ne[i], ov[i], un[i], rv[i], seu[i]} !==
                    {md[i], 3'(msz(i)), msz(i) == 0, msz(i) == 5, msz(i) >= 3, msz(i) <= 1, mov[i], mun[i], mrv[i], 1'b0}) begin
                    errs++;
                    $display("FAIL random cyc%0d dut%0d got d=%h cnt=%0d ov/un/rv/seu=%b%b%b%b want d=%h cnt=%0d ov/un/rv=%b%b%b",
                             n, i, dout[i], cnt[i], ov[i], un[i], rv[i], seu[i], md[i], msz(i), mov[i], mun[i], mrv[i]);
                end
            end
        end
    endtask
    task automatic test_reset_midfill();
        drive(0, 0, 1, 0, 8'h00);
        drive(1, 0, 0, 0, 8'h12);
        drive(0, 1, 0, 0, 8'h00);
        drive(1, 1, 0, 0, 8'h34);
        drive(1, 0, 0, 1, 8'h56);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({cnt[i], emp[i], ful[i], nf[i], ne[i], ov[i], un[i], rv[i], seu[i], dout[i]} !== {3'd0, 8'b10010000, 8'h00}) begin
                errs++;
                $display("FAIL reset_midfill dut%0d got cnt=%0d e/f/nf/ne/ov/un/rv/seu=%b%b%b%b%b%b%b%b d=%h want cnt=0 10010000 d=00",
                         i, cnt[i], emp[i], ful[i], nf[i], ne[i], ov[i], un[i], rv[i], seu[i], dout[i]);
            end
        end
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_wrap();
        test_clear();
        test_seu();
        test_random();
        test_reset_midfill();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
